hex_display_scanner: RTL and testbench



---
 rtl/hex_display_scanner.sv | 114 +++++++++++
 tb/tb_hex_display_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a hex value onto one digit slot at a time, with a
// double-buffered display register committed only at frame boundaries.
// Latency: outputs are registered and show the current slot one cycle later.
// Backpressure: none; loads are accepted every cycle, and the last load before a commit wins.
module hex_display_scanner #(
  parameter int NUM_DIGITS        = 8,
  parameter int REFRESH_DIV       = 50000,
  parameter int ENABLE_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      blank_leading,
  output logic [3:0]                nibble,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      blank,
  output logic                      update_pending,
  output logic                      frame_done
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  // Pattern that lights nothing at the configured polarity.
  localparam logic [NUM_DIGITS-1:0] EN_IDLE = (ENABLE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         digit_idx;
  logic [VW-1:0]         shadow_reg;
  logic [VW-1:0]         disp_reg;
  logic                  pending;

  logic                  tick;
  logic                  frame_end;
  logic [NUM_DIGITS:0]   zero_from;
  logic [VW-1:0]         disp_shifted;
  logic [3:0]            slot_nibble;
  logic                  slot_blank;
  logic [NUM_DIGITS-1:0] en_active;
  logic [NUM_DIGITS-1:0] en_next;

  assign tick      = (div_cnt == DIV_MAX);
  assign frame_end = tick && (digit_idx == IDX_MAX);

  // Dwell counter and scan position; the slot advances once per dwell period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (tick) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // Double buffer: loads land in the shadow and move to the display only at a
  // frame boundary; a load on the boundary itself goes straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
      disp_reg   <= '0;
      pending    <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        shadow_reg <= value;
        disp_reg   <= value;
      end else if (pending) begin
        disp_reg   <= shadow_reg;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow_reg <= value;
      pending    <= 1'b1;
    end
  end

  // Slot decode: zero_from[i] is set when nibbles i and above are all zero,
  // which is what makes digit i a leading zero.
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (disp_reg[4*i +: 4] == 4'h0);
    end
    disp_shifted = disp_reg >> (4 * int'(digit_idx));
    slot_nibble  = disp_shifted[3:0];
    slot_blank   = blank_leading && (digit_idx != '0) && zero_from[digit_idx];
    en_active    = slot_blank ? '0 : (NUM_DIGITS'(1) << digit_idx);
    en_next      = (ENABLE_ACTIVE_LOW != 0) ? ~en_active : en_active;
  end

  // Registered outputs: the slot decode and the boundary flag are each delayed one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble         <= 4'h0;
      digit_en       <= EN_IDLE;
      blank          <= 1'b1;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      nibble         <= slot_nibble;
      digit_en       <= en_next;
      blank          <= slot_blank;
      update_pending <= pending;
      frame_done     <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a 4-cycle-dwell instance and a 1-cycle-dwell
// instance share stimulus; a cycle-count model predicts both, plus literal pins.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_leading = 1'b0;

  logic [3:0]  o_nib   [2];
  logic [3:0]  o_en    [2];
  logic        o_blank [2];
  logic        o_up    [2];
  logic        o_fd    [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ENABLE_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_leading(blank_leading),
    .nibble(o_nib[0]), .digit_en(o_en[0]), .blank(o_blank[0]),
    .update_pending(o_up[0]), .frame_done(o_fd[0])
  );

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(1), .ENABLE_ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_leading(blank_leading),
    .nibble(o_nib[1]), .digit_en(o_en[1]), .blank(o_blank[1]),
    .update_pending(o_up[1]), .frame_done(o_fd[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: time since reset release fixes the slot; frames are 4*R cycles long.
  int          m_t    [2];
  int          m_div  [2] = '{4, 1};
  logic [15:0] m_disp [2];
  logic [15:0] m_shad [2];
  bit          m_pend [2];
  bit          m_valid = 1'b0;
  logic [3:0]  e_nib  [2];
  logic [3:0]  e_en   [2];
  logic        e_blank[2];
  logic        e_up   [2];
  logic        e_fd   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_t[k] = 0; m_disp[k] = 16'h0; m_shad[k] = 16'h0; m_pend[k] = 1'b0;
        e_nib[k] = 4'h0; e_en[k] = 4'hF; e_blank[k] = 1'b1; e_up[k] = 1'b0; e_fd[k] = 1'b0;
      end else begin
        int  slot;
        bit  bnd;
        bit  blk;
        slot = (m_t[k] / m_div[k]) % 4;
        bnd  = (m_t[k] % (4 * m_div[k])) == (4 * m_div[k] - 1);
        blk  = blank_leading && (slot != 0) && ((m_disp[k] >> (4 * slot)) == 16'h0);
        e_nib[k]   = 4'((m_disp[k] >> (4 * slot)) & 16'hF);
        e_en[k]    = blk ? 4'hF : ~(4'(1) << slot);
        e_blank[k] = blk;
        e_up[k]    = m_pend[k];
        e_fd[k]    = bnd;
        if (bnd) begin
          if (load) begin m_disp[k] = value; m_shad[k] = value; end
          else if (m_pend[k]) m_disp[k] = m_shad[k];
          m_pend[k] = 1'b0;
        end else if (load) begin
          m_shad[k] = value; m_pend[k] = 1'b1;
        end
        m_t[k]++;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("nibble[%0d]", k), 32'(o_nib[k]), 32'(e_nib[k]));
        chk($sformatf("digit_en[%0d]", k), 32'(o_en[k]), 32'(e_en[k]));
        chk($sformatf("blank[%0d]", k), 32'(o_blank[k]), 32'(e_blank[k]));
        chk($sformatf("update_pending[%0d]", k), 32'(o_up[k]), 32'(e_up[k]));
        chk($sformatf("frame_done[%0d]", k), 32'(o_fd[k]), 32'(e_fd[k]));
        chk($sformatf("onehot[%0d]", k), 32'($countones(~o_en[k]) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_en(input logic [3:0] en);
    bit found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (o_en[0] == en) found = 1'b1;
    end
    if (!found) chk("wait_digit_en timeout", 32'(o_en[0]), 32'(en));
  endtask

  task automatic wait_fd();
    bit found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (o_fd[0]) found = 1'b1;
    end
    if (!found) chk("wait_frame_done timeout", 32'(o_fd[0]), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; value = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    int dwell;
    int lit;
    logic [3:0] walk1 [3] = '{4'b1101, 4'b1011, 4'b0111};

    // 1: reset, then idle scanning of an all-zero value
    repeat (2) @(negedge clk);
    chk("reset digit_en", 32'(o_en[0]), 32'hF);
    chk("reset blank", 32'(o_blank[0]), 32'd1);
    chk("reset nibble", 32'(o_nib[0]), 32'd0);
    chk("reset update_pending", 32'(o_up[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first slot digit_en", 32'(o_en[0]), 32'b1110);
    chk("first slot R1 digit_en", 32'(o_en[1]), 32'b1110);
    fd_cnt = 0; dwell = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i < 3) chk("R1 walk", 32'(o_en[1]), 32'(walk1[i]));
      if (o_fd[0]) fd_cnt++;
      if (o_en[0] == 4'b1101) dwell++;
    end
    chk("frame_done pulses per 32 cycles", 32'(fd_cnt), 32'd2);
    chk("digit1 dwell cycles", 32'(dwell), 32'd8);

    // 2: mid-frame load commits at the next boundary
    do_load(16'h1234);
    @(negedge clk);
    chk("pending after load", 32'(o_up[0]), 32'd1);
    wait_fd();
    wait_en(4'b1110); chk("1234 digit0", 32'(o_nib[0]), 32'h4);
    wait_en(4'b1101); chk("1234 digit1", 32'(o_nib[0]), 32'h3);
    wait_en(4'b1011); chk("1234 digit2", 32'(o_nib[0]), 32'h2);
    wait_en(4'b0111); chk("1234 digit3", 32'(o_nib[0]), 32'h1);
    chk("pending cleared", 32'(o_up[0]), 32'd0);

    // 3: two loads in one frame, last wins
    wait_fd();
    do_load(16'hAAAA);
    @(negedge clk);
    do_load(16'h5A5F);
    wait_fd();
    wait_en(4'b1110); chk("5A5F digit0", 32'(o_nib[0]), 32'hF);
    wait_en(4'b1101); chk("5A5F digit1", 32'(o_nib[0]), 32'h5);
    wait_en(4'b1011); chk("5A5F digit2", 32'(o_nib[0]), 32'hA);
    wait_en(4'b0111); chk("5A5F digit3", 32'(o_nib[0]), 32'h5);

    // 4: load exactly on the boundary tick goes straight to the display
    repeat (2) @(negedge clk);
    do_load(16'h00C0);
    chk("boundary frame_done", 32'(o_fd[0]), 32'd1);
    @(negedge clk);
    chk("boundary load no pending", 32'(o_up[0]), 32'd0);
    chk("00C0 digit0 en", 32'(o_en[0]), 32'b1110);
    chk("00C0 digit0", 32'(o_nib[0]), 32'h0);
    wait_en(4'b1101); chk("00C0 digit1", 32'(o_nib[0]), 32'hC);
    chk("boundary load still no pending", 32'(o_up[0]), 32'd0);

    // 5: leading-zero blanking
    blank_leading = 1'b1;
    do_load(16'h0050);
    wait_fd();
    wait_en(4'b1101); chk("0050 digit1", 32'(o_nib[0]), 32'h5);
    repeat (4) @(negedge clk);
    chk("0050 digit2 blank", 32'(o_blank[0]), 32'd1);
    chk("0050 digit2 en", 32'(o_en[0]), 32'hF);
    repeat (4) @(negedge clk);
    chk("0050 digit3 blank", 32'(o_blank[0]), 32'd1);
    do_load(16'h0000);
    wait_fd();
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!o_blank[0] && o_en[0] == 4'b1110 && o_nib[0] == 4'h0) lit++;
    end
    chk("zero value lit cycles", 32'(lit), 32'd4);

    // 6: reset during digit 2 with a load pending
    blank_leading = 1'b0;
    wait_fd();
    do_load(16'h7777);
    wait_en(4'b1011);
    chk("pending before reset", 32'(o_up[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset digit_en", 32'(o_en[0]), 32'hF);
    chk("mid reset update_pending", 32'(o_up[0]), 32'd0);
    dwell = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("R1 restart digit0", 32'(o_en[1]), 32'b1110);
      if (i == 1) chk("R1 restart digit1", 32'(o_en[1]), 32'b1101);
      if (o_en[0] == 4'b1110) dwell++;
    end
    chk("restart dwell", 32'(dwell), 32'd4);
    wait_fd();
    wait_en(4'b1110); chk("discarded load digit0", 32'(o_nib[0]), 32'h0);
    wait_en(4'b1101); chk("discarded load digit1", 32'(o_nib[0]), 32'h0);
    chk("discarded load pending", 32'(o_up[0]), 32'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
